// File: rtl/vpg_mode_pkg.sv
// Shared types and the video mode table for the VPG mode sequencer.
package vpg_mode_pkg;

    localparam int NUM_MODES_MAX = 16;
    localparam int MODE_W        = 4;
    localparam int TIM_W         = 12;
    localparam int WAIT_CNT_W    = 22;
    localparam int HOLD_CNT_W    = 5;
    localparam int LOCK_CNT_W    = 11;

    // One row of vga_generator timing; field order is the output order.
    typedef struct packed {
        logic [TIM_W-1:0] h_total;
        logic [TIM_W-1:0] h_sync;
        logic [TIM_W-1:0] h_start;
        logic [TIM_W-1:0] h_end;
        logic [TIM_W-1:0] v_total;
        logic [TIM_W-1:0] v_sync;
        logic [TIM_W-1:0] v_start;
        logic [TIM_W-1:0] v_end;
        logic [TIM_W-1:0] v_active_14;
        logic [TIM_W-1:0] v_active_24;
        logic [TIM_W-1:0] v_active_34;
    } mode_timing_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RECONF  = 3'd3,
        ST_LOCK    = 3'd4
    } state_e;

    // 0:640x480@60, 1:800x600@60, 2:1280x720@60, 3:1920x1080@60
    localparam mode_timing_t MODE_TABLE [4] = '{
        '{12'd799,  12'd95,  12'd141, 12'd781,  12'd524,  12'd1, 12'd34, 12'd514,  12'd154, 12'd274, 12'd394},
        '{12'd1055, 12'd127, 12'd215, 12'd1015, 12'd627,  12'd3, 12'd26, 12'd626,  12'd176, 12'd326, 12'd476},
        '{12'd1649, 12'd39,  12'd259, 12'd1539, 12'd749,  12'd4, 12'd24, 12'd744,  12'd204, 12'd384, 12'd564},
        '{12'd2199, 12'd43,  12'd189, 12'd2109, 12'd1124, 12'd4, 12'd40, 12'd1120, 12'd310, 12'd580, 12'd850}
    };

    // Out-of-table indices fall back to mode 0 so the ROM never emits garbage.
    function automatic mode_timing_t mode_row(input logic [MODE_W-1:0] idx);
        mode_row = MODE_TABLE[0];
        if (idx < 4'd4) mode_row = MODE_TABLE[idx[1:0]];
    endfunction

endpackage

// File: rtl/vpg_mode_rom.sv
// Registered mode-index to timing-row lookup; the register is the timing hold.
module vpg_mode_rom
    import vpg_mode_pkg::*;
#(
    parameter int DEFAULT_MODE = 0
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              load_i,
    input  logic [MODE_W-1:0] mode_i,
    output mode_timing_t      timing_o
);

    localparam logic [MODE_W-1:0] DEF_M = MODE_W'(DEFAULT_MODE);

    mode_timing_t timing_q;

    // Timing only changes on an explicit load, which happens while the generator is in reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) timing_q <= mode_row(DEF_M);
        else if (load_i) timing_q <= mode_row(mode_i);
    end

    assign timing_o = timing_q;

endmodule

// File: rtl/vpg_mode_ctrl.sv
// Video-mode sequencer: frame-aligned, glitch-free mode switch for vga_generator
// (wait vsync -> hold generator in reset -> PLL reconfig -> lock-stable wait -> release).
module vpg_mode_ctrl
    import vpg_mode_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int DEFAULT_MODE = 0,
    parameter int HOLD_CYCLES  = 16,
    parameter int LOCK_CYCLES  = 1024,
    parameter int VS_TIMEOUT   = 1 << 22
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [MODE_W-1:0] mode_sel_i,
    input  logic              mode_req_i,
    input  logic              vga_vs_i,
    input  logic              pll_ack_i,
    input  logic              pll_locked_i,
    output logic              pll_req_o,
    output logic [MODE_W-1:0] pll_mode_o,
    output logic              gen_reset_n_o,
    output logic [TIM_W-1:0]  h_total_o,
    output logic [TIM_W-1:0]  h_sync_o,
    output logic [TIM_W-1:0]  h_start_o,
    output logic [TIM_W-1:0]  h_end_o,
    output logic [TIM_W-1:0]  v_total_o,
    output logic [TIM_W-1:0]  v_sync_o,
    output logic [TIM_W-1:0]  v_start_o,
    output logic [TIM_W-1:0]  v_end_o,
    output logic [TIM_W-1:0]  v_active_14_o,
    output logic [TIM_W-1:0]  v_active_24_o,
    output logic [TIM_W-1:0]  v_active_34_o,
    output logic [MODE_W-1:0] mode_cur_o,
    output logic              busy_o,
    output logic              req_err_o
);

    localparam logic [MODE_W-1:0]     DEF_M     = MODE_W'(DEFAULT_MODE);
    localparam logic [MODE_W:0]       NM        = (MODE_W+1)'(NUM_MODES);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(VS_TIMEOUT - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LOCK_CNT_W-1:0] LOCK_DONE = LOCK_CNT_W'(LOCK_CYCLES);

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [MODE_W-1:0]     pend_mode_q, pend_mode_d;
    logic [MODE_W-1:0]     mode_cur_q, mode_cur_d;
    logic                  pll_req_q, pll_req_d;
    logic [MODE_W-1:0]     pll_mode_q, pll_mode_d;
    logic                  gen_rst_n_q, gen_rst_n_d;
    logic                  req_err_q, req_err_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  vs_q;
    logic                  lk1_q, lk2_q;
    logic                  req_ok, vs_fall, rom_load;
    mode_timing_t          timing;

    assign req_ok  = mode_req_i && ({1'b0, mode_sel_i} < NM);
    assign vs_fall = vs_q && !vga_vs_i;

    // pll_locked comes from the PLL domain; plain 2-FF synchroniser.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lk1_q <= 1'b0;
            lk2_q <= 1'b0;
            vs_q  <= 1'b1;
        end else begin
            lk1_q <= pll_locked_i;
            lk2_q <= lk1_q;
            vs_q  <= vga_vs_i;
        end
    end

    // State and control registers; reset starts in LOCK so the first release waits for lock.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_LOCK;
            pending_q   <= 1'b0;
            pend_mode_q <= DEF_M;
            mode_cur_q  <= DEF_M;
            pll_req_q   <= 1'b0;
            pll_mode_q  <= DEF_M;
            gen_rst_n_q <= 1'b0;
            req_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            lock_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pend_mode_q <= pend_mode_d;
            mode_cur_q  <= mode_cur_d;
            pll_req_q   <= pll_req_d;
            pll_mode_q  <= pll_mode_d;
            gen_rst_n_q <= gen_rst_n_d;
            req_err_q   <= req_err_d;
            wait_cnt_q  <= wait_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    // Next-state, request latch and the single-point timing load on HOLD entry.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pend_mode_d = pend_mode_q;
        mode_cur_d  = mode_cur_q;
        pll_req_d   = pll_req_q;
        pll_mode_d  = pll_mode_q;
        gen_rst_n_d = gen_rst_n_q;
        rom_load    = 1'b0;
        req_err_d   = mode_req_i && !req_ok;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    if (pend_mode_q != mode_cur_q) state_d = ST_WAIT_VS;
                    else                           pending_d = 1'b0;
                end
            end
            ST_WAIT_VS: begin
                if (vs_fall || wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_HOLD;
                    gen_rst_n_d = 1'b0;
                    rom_load    = 1'b1;
                    mode_cur_d  = pend_mode_q;
                    pending_d   = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RECONF;
                    pll_req_d  = 1'b1;
                    pll_mode_d = mode_cur_q;
                end
            end
            ST_RECONF: begin
                if (pll_ack_i) begin
                    state_d   = ST_LOCK;
                    pll_req_d = 1'b0;
                end
            end
            ST_LOCK: begin
                if (lock_cnt_q == LOCK_DONE) begin
                    state_d     = ST_IDLE;
                    gen_rst_n_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_LOCK;
                gen_rst_n_d = 1'b0;
            end
        endcase

        // A fresh valid request always wins over a same-cycle clear.
        if (req_ok) begin
            pending_d   = 1'b1;
            pend_mode_d = mode_sel_i;
        end
    end

    // Counters clear on any state change and saturate at their terminal value.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        hold_cnt_d = hold_cnt_q;
        lock_cnt_d = lock_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
            hold_cnt_d = '0;
            lock_cnt_d = '0;
        end else begin
            if (state_q == ST_WAIT_VS && wait_cnt_q != WAIT_LAST)
                wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
            if (state_q == ST_HOLD && hold_cnt_q != HOLD_LAST)
                hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
            if (state_q == ST_LOCK) begin
                if (!lk2_q)                     lock_cnt_d = '0;
                else if (lock_cnt_q != LOCK_DONE) lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
            end
        end
    end

    vpg_mode_rom #(.DEFAULT_MODE(DEFAULT_MODE)) u_rom (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (rom_load),
        .mode_i    (pend_mode_q),
        .timing_o  (timing)
    );

    assign pll_req_o     = pll_req_q;
    assign pll_mode_o    = pll_mode_q;
    assign gen_reset_n_o = gen_rst_n_q;
    assign mode_cur_o    = mode_cur_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign req_err_o     = req_err_q;
    assign h_total_o     = timing.h_total;
    assign h_sync_o      = timing.h_sync;
    assign h_start_o     = timing.h_start;
    assign h_end_o       = timing.h_end;
    assign v_total_o     = timing.v_total;
    assign v_sync_o      = timing.v_sync;
    assign v_start_o     = timing.v_start;
    assign v_end_o       = timing.v_end;
    assign v_active_14_o = timing.v_active_14;
    assign v_active_24_o = timing.v_active_24;
    assign v_active_34_o = timing.v_active_34;

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// Directed bench for vpg_mode_ctrl: request table plus hand-written switch sequences.
module tb_vpg_mode_ctrl;

    localparam int LOCK_N = 1024;
    localparam int HOLD_N = 16;
    localparam int VS_TO  = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, mode_req, vga_vs, pll_ack, pll_locked;
    logic [3:0]  mode_sel;
    logic        pll_req, gen_reset_n, busy, req_err;
    logic [3:0]  pll_mode, mode_cur;
    logic [11:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
    logic [11:0] v_a14, v_a24, v_a34;

    vpg_mode_ctrl #(
        .NUM_MODES(4), .DEFAULT_MODE(0), .HOLD_CYCLES(HOLD_N),
        .LOCK_CYCLES(LOCK_N), .VS_TIMEOUT(VS_TO)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .mode_sel_i(mode_sel), .mode_req_i(mode_req),
        .vga_vs_i(vga_vs), .pll_ack_i(pll_ack), .pll_locked_i(pll_locked),
        .pll_req_o(pll_req), .pll_mode_o(pll_mode), .gen_reset_n_o(gen_reset_n),
        .h_total_o(h_total), .h_sync_o(h_sync), .h_start_o(h_start), .h_end_o(h_end),
        .v_total_o(v_total), .v_sync_o(v_sync), .v_start_o(v_start), .v_end_o(v_end),
        .v_active_14_o(v_a14), .v_active_24_o(v_a24), .v_active_34_o(v_a34),
        .mode_cur_o(mode_cur), .busy_o(busy), .req_err_o(req_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [3:0] sel);
        mode_sel = sel;
        mode_req = 1'b1;
        step();
        mode_req = 1'b0;
    endtask

    typedef struct {
        logic [3:0] sel;
        logic       err;
    } req_vec_t;

    req_vec_t vecs [4];
    int n;

    initial begin
        // Requests issued in IDLE with mode 0 current: none may start a switch.
        vecs[0] = '{sel: 4'd7,  err: 1'b1};
        vecs[1] = '{sel: 4'd4,  err: 1'b1};
        vecs[2] = '{sel: 4'd15, err: 1'b1};
        vecs[3] = '{sel: 4'd0,  err: 1'b0};

        reset_n = 1'b0; mode_req = 1'b0; mode_sel = 4'd0;
        vga_vs = 1'b1; pll_ack = 1'b0; pll_locked = 1'b1;
        step(); step();

        // Reset values
        chk("rst gen_reset_n", int'(gen_reset_n), 0);
        chk("rst pll_req", int'(pll_req), 0);
        chk("rst busy", int'(busy), 1);
        chk("rst req_err", int'(req_err), 0);
        chk("rst mode_cur", int'(mode_cur), 0);
        chk("rst h_total", int'(h_total), 799);

        // Startup: lock-stable wait then release, no PLL request
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            step(); n++;
            if (gen_reset_n) break;
        end
        chk("startup release cycles", n, LOCK_N + 3);
        chk("startup h_total", int'(h_total), 799);
        chk("startup v_total", int'(v_total), 524);
        chk("startup v_start", int'(v_start), 34);
        chk("startup mode_cur", int'(mode_cur), 0);
        chk("startup busy", int'(busy), 0);
        chk("startup pll_req", int'(pll_req), 0);

        // Table: rejected / no-op requests
        for (int i = 0; i < 4; i++) begin
            pulse_req(vecs[i].sel);
            chk($sformatf("vec%0d req_err", i), int'(req_err), int'(vecs[i].err));
            step();
            chk($sformatf("vec%0d req_err once", i), int'(req_err), 0);
            step();
            chk($sformatf("vec%0d busy", i), int'(busy), 0);
            chk($sformatf("vec%0d mode_cur", i), int'(mode_cur), 0);
            chk($sformatf("vec%0d h_total", i), int'(h_total), 799);
            chk($sformatf("vec%0d gen_reset_n", i), int'(gen_reset_n), 1);
        end

        // Switch to mode 2 on a vsync falling edge 500 cycles after the request
        pulse_req(4'd2);
        chk("m2 idle after 1", int'(busy), 0);
        step();
        chk("m2 busy after 2", int'(busy), 1);
        repeat (498) step();
        chk("m2 gen_reset_n before vs", int'(gen_reset_n), 1);
        chk("m2 h_total before vs", int'(h_total), 799);
        vga_vs = 1'b0;
        step();
        chk("m2 gen_reset_n at vs", int'(gen_reset_n), 0);
        chk("m2 h_total", int'(h_total), 1649);
        chk("m2 v_end", int'(v_end), 744);
        chk("m2 mode_cur", int'(mode_cur), 2);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step(); n++;
            if (k == 3) vga_vs = 1'b1;
            if (pll_req) break;
        end
        chk("m2 hold cycles", n, HOLD_N);
        chk("m2 pll_mode", int'(pll_mode), 2);

        // RECONF: no timeout; two requests, the latest wins
        pll_locked = 1'b0;
        repeat (50) step();
        pulse_req(4'd1);
        repeat (20) step();
        pulse_req(4'd3);
        repeat (130) step();
        chk("reconf pll_req held", int'(pll_req), 1);
        chk("reconf pll_mode stable", int'(pll_mode), 2);
        pll_ack = 1'b1;
        step();
        pll_ack = 1'b0;
        chk("ack pll_req drop", int'(pll_req), 0);
        chk("ack busy", int'(busy), 1);
        pll_locked = 1'b1;
        repeat (600) step();
        chk("pre-glitch gen_reset_n", int'(gen_reset_n), 0);
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            step(); n++;
            if (gen_reset_n) break;
        end
        chk("glitch release cycles", n, LOCK_N + 3);
        chk("release busy", int'(busy), 0);

        // Pending mode 3 is served right after release
        step();
        chk("m3 busy", int'(busy), 1);
        repeat (10) step();
        vga_vs = 1'b0;
        step();
        vga_vs = 1'b1;
        chk("m3 h_total", int'(h_total), 2199);
        chk("m3 mode_cur", int'(mode_cur), 3);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step(); n++;
            if (pll_req) break;
        end
        chk("m3 hold cycles", n, HOLD_N);
        chk("m3 pll_mode", int'(pll_mode), 3);
        pll_ack = 1'b1;
        step();
        pll_ack = 1'b0;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            step(); n++;
            if (gen_reset_n) break;
        end
        chk("m3 release cycles", n, LOCK_N + 1);
        repeat (20) step();
        chk("m3 no further switch", int'(busy), 0);
        pulse_req(4'd3);
        repeat (3) step();
        chk("same mode busy", int'(busy), 0);
        chk("same mode req_err", int'(req_err), 0);
        chk("same mode mode_cur", int'(mode_cur), 3);

        // vsync stuck high: timeout, with a retarget mid-wait that must not restart it
        pulse_req(4'd2);
        step();
        chk("to busy", int'(busy), 1);
        n = 0;
        for (int k = 0; k < VS_TO + 100; k++) begin
            step(); n++;
            if (!gen_reset_n) break;
            mode_req = (n == 100);
            mode_sel = 4'd1;
        end
        mode_req = 1'b0;
        chk("to wait cycles", n, VS_TO);
        chk("to h_total", int'(h_total), 1055);
        chk("to mode_cur", int'(mode_cur), 1);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step(); n++;
            if (pll_req) break;
        end
        chk("to hold cycles", n, HOLD_N);
        chk("to pll_mode", int'(pll_mode), 1);

        // Mid-RECONF reset
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk("midrst pll_req", int'(pll_req), 0);
        chk("midrst gen_reset_n", int'(gen_reset_n), 0);
        chk("midrst busy", int'(busy), 1);
        chk("midrst mode_cur", int'(mode_cur), 0);
        chk("midrst pll_mode", int'(pll_mode), 0);
        chk("midrst h_total", int'(h_total), 799);
        chk("midrst v_total", int'(v_total), 524);
        chk("midrst req_err", int'(req_err), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
